// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill sequencer: captures one miss, issues a line-aligned
// memory read, assembles the response beats and writes the whole line into the victim way.
module icache_refill_ctrl #(
    parameter int NUM_WAYS            = 4,
    parameter int NUM_BANKS           = 4,
    parameter int SETS_PER_BANK_WIDTH = 8,
    parameter int BLOCK_WIDTH         = 512,
    parameter int MEM_DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH          = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           miss_valid_i,
    output logic                           miss_ready_o,
    input  logic [ADDR_WIDTH-1:0]          miss_addr_i,
    input  logic [NUM_WAYS-1:0]            miss_way_i,
    output logic                           mem_req_valid_o,
    input  logic                           mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]          mem_req_addr_o,
    input  logic                           mem_rvalid_i,
    input  logic [MEM_DATA_WIDTH-1:0]      mem_rdata_i,
    output logic [SETS_PER_BANK_WIDTH-1:0] w_bank_addr_o,
    output logic [$clog2(NUM_BANKS)-1:0]   w_bank_sel_o,
    output logic [NUM_WAYS-1:0]            we_way_mask_o,
    output logic [BLOCK_WIDTH-1:0]         wdata_o,
    output logic                           busy_o,
    output logic                           refill_done_o
);

    localparam int BEATS = BLOCK_WIDTH / MEM_DATA_WIDTH;
    localparam int OFF   = $clog2(BLOCK_WIDTH / 8);
    localparam int BS    = $clog2(NUM_BANKS);
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-OFF){1'b1}}, {OFF{1'b0}}};

    // Handshakes: a miss transfers on a rising edge with miss_valid_i & miss_ready_o,
    // the memory request on mem_req_valid_o & mem_req_ready_i; response beats have no backpressure.
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_WRITE
    } state_e;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]          line_addr_q, line_addr_d;
    logic [BS-1:0]                  bank_q, bank_d;
    logic [SETS_PER_BANK_WIDTH-1:0] set_q, set_d;
    logic [NUM_WAYS-1:0]            way_q, way_d;
    logic [BLOCK_WIDTH-1:0]         buf_q, buf_d;
    logic                           miss_ready_q, miss_ready_d;
    logic                           req_valid_q, req_valid_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic [NUM_WAYS-1:0]            we_mask_q, we_mask_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_addr_d = line_addr_q;
        bank_d      = bank_q;
        set_d       = set_q;
        way_d       = way_q;
        buf_d       = buf_q;

        case (state_q)
            S_IDLE: begin
                if (miss_valid_i) begin
                    line_addr_d = miss_addr_i & LINE_MASK;
                    bank_d      = miss_addr_i[OFF +: BS];
                    set_d       = miss_addr_i[OFF+BS +: SETS_PER_BANK_WIDTH];
                    way_d       = miss_way_i;
                    cnt_d       = '0;
                    buf_d       = '0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready_i) begin
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (mem_rvalid_i) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (cnt_q == CNT_W'(b)) begin
                            buf_d[b*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_rdata_i;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are registered yet aligned with it.
        miss_ready_d = (state_d == S_IDLE);
        req_valid_d  = (state_d == S_REQ);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_WRITE);
        we_mask_d    = (state_d == S_WRITE) ? way_d : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            line_addr_q  <= '0;
            bank_q       <= '0;
            set_q        <= '0;
            way_q        <= '0;
            buf_q        <= '0;
            miss_ready_q <= 1'b1;
            req_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            we_mask_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_addr_q  <= line_addr_d;
            bank_q       <= bank_d;
            set_q        <= set_d;
            way_q        <= way_d;
            buf_q        <= buf_d;
            miss_ready_q <= miss_ready_d;
            req_valid_q  <= req_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            we_mask_q    <= we_mask_d;
        end
    end

    assign miss_ready_o    = miss_ready_q;
    assign mem_req_valid_o = req_valid_q;
    assign mem_req_addr_o  = line_addr_q;
    assign w_bank_addr_o   = set_q;
    assign w_bank_sel_o    = bank_q;
    assign we_way_mask_o   = we_mask_q;
    assign wdata_o         = buf_q;
    assign busy_o          = busy_q;
    assign refill_done_o   = done_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboarded bench for icache_refill_ctrl: each line write is compared against the
// entry queued when its miss was issued.
module tb_icache_refill_ctrl;

    localparam int EW = 4 + 2 + 8 + 512;

    logic         clk_i;
    logic         rst_ni;
    logic         miss_valid_i;
    logic         miss_ready_o;
    logic [31:0]  miss_addr_i;
    logic [3:0]   miss_way_i;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i;
    logic [31:0]  mem_req_addr_o;
    logic         mem_rvalid_i;
    logic [63:0]  mem_rdata_i;
    logic [7:0]   w_bank_addr_o;
    logic [1:0]   w_bank_sel_o;
    logic [3:0]   we_way_mask_o;
    logic [511:0] wdata_o;
    logic         busy_o;
    logic         refill_done_o;

    int errors = 0;
    int checks = 0;
    int writes = 0;
    logic [EW-1:0] exp_q[$];

    icache_refill_ctrl dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .miss_valid_i    (miss_valid_i),
        .miss_ready_o    (miss_ready_o),
        .miss_addr_i     (miss_addr_i),
        .miss_way_i      (miss_way_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .w_bank_addr_o   (w_bank_addr_o),
        .w_bank_sel_o    (w_bank_sel_o),
        .we_way_mask_o   (we_way_mask_o),
        .wdata_o         (wdata_o),
        .busy_o          (busy_o),
        .refill_done_o   (refill_done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [63:0] junk();
        return {$urandom, $urandom};
    endfunction

    // 64-byte lines, 4 banks: bank = addr[7:6], set = addr[15:8].
    function automatic logic [EW-1:0] exp_entry(input logic [31:0] a, input logic [3:0] w,
                                               input logic [511:0] line);
        return {w, a[7:6], a[15:8], line};
    endfunction

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (refill_done_o === 1'b1) begin
                logic [EW-1:0] e;
                writes++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got mask=%b bank=%0d set=%h", we_way_mask_o,
                             w_bank_sel_o, w_bank_addr_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({we_way_mask_o, w_bank_sel_o, w_bank_addr_o, wdata_o} !== e) begin
                        errors++;
                        $display("FAIL line_write got mask=%b bank=%0d set=%h data=%h required mask=%b bank=%0d set=%h data=%h",
                                 we_way_mask_o, w_bank_sel_o, w_bank_addr_o, wdata_o,
                                 e[525:522], e[521:520], e[519:512], e[511:0]);
                    end
                end
            end
            checks++;
            if (we_way_mask_o !== 4'b0 && refill_done_o !== 1'b1) begin
                errors++;
                $display("FAIL stray_we got mask=%b outside the write cycle, required 0000", we_way_mask_o);
            end
        end
    end

    task automatic send_miss(input logic [31:0] a, input logic [3:0] w);
        int n = 0;
        miss_addr_i  = a;
        miss_way_i   = w;
        miss_valid_i = 1'b1;
        while (miss_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL miss_handshake got no miss_ready_o within 50 cycles");
        end
        @(negedge clk_i);
        miss_valid_i = 1'b0;
    endtask

    // Entered at the negedge of the first REQ cycle; returns in the IDLE cycle after WRITE.
    task automatic serve(input logic [31:0] req_addr, input logic [511:0] line,
                         input int req_delay, input bit gap, input bit stray);
        for (int i = 0; i < req_delay; i++) begin
            mem_rvalid_i = stray;
            mem_rdata_i  = junk();
            checks++;
            if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== req_addr) begin
                errors++;
                $display("FAIL req_hold got valid=%b addr=%h required valid=1 addr=%h",
                         mem_req_valid_o, mem_req_addr_o, req_addr);
            end
            @(negedge clk_i);
        end
        checks++;
        if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== req_addr) begin
            errors++;
            $display("FAIL req_issue got valid=%b addr=%h required valid=1 addr=%h",
                     mem_req_valid_o, mem_req_addr_o, req_addr);
        end
        mem_req_ready_i = 1'b1;
        mem_rvalid_i    = stray;
        mem_rdata_i     = junk();
        @(negedge clk_i);
        mem_req_ready_i = 1'b0;
        for (int b = 0; b < 8; b++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = line[b*64 +: 64];
            @(negedge clk_i);
            checks++;
            if (refill_done_o !== logic'(b == 7)) begin
                errors++;
                $display("FAIL done_timing after beat %0d got done=%b required %b", b,
                         refill_done_o, logic'(b == 7));
            end
            if (gap && b != 7) begin
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = junk();
                @(negedge clk_i);
            end
        end
        mem_rvalid_i = stray;
        mem_rdata_i  = junk();
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        checks++;
        if (miss_ready_o !== 1'b1 || refill_done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL post_write got ready=%b done=%b busy=%b required 1 0 0",
                     miss_ready_o, refill_done_o, busy_o);
        end
    endtask

    task automatic test_reset();
        rst_ni          = 1'b0;
        miss_valid_i    = 1'b0;
        miss_addr_i     = '0;
        miss_way_i      = '0;
        mem_req_ready_i = 1'b0;
        mem_rvalid_i    = 1'b0;
        mem_rdata_i     = '0;
        #12;
        checks++;
        if (miss_ready_o !== 1'b1 || busy_o !== 1'b0 || refill_done_o !== 1'b0 ||
            mem_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got ready=%b busy=%b done=%b req=%b required 1 0 0 0",
                     miss_ready_o, busy_o, refill_done_o, mem_req_valid_o);
        end
        checks++;
        if (we_way_mask_o !== 4'b0 || wdata_o !== 512'b0 || w_bank_addr_o !== 8'h0 ||
            w_bank_sel_o !== 2'b0 || mem_req_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got we=%b bank=%0d set=%h addr=%h required all zero",
                     we_way_mask_o, w_bank_sel_o, w_bank_addr_o, mem_req_addr_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_basic_refill();
        logic [511:0] line;
        logic [3:0]   nib;
        int           cyc;
        for (int b = 0; b < 8; b++) begin
            nib = 4'(b + 1);
            line[b*64 +: 64] = {16{nib}};
        end
        exp_q.push_back(exp_entry(32'h0000_1A40, 4'b0100, line));
        send_miss(32'h0000_1A40, 4'b0100);
        cyc = 1;
        checks++;
        if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h0000_1A40) begin
            errors++;
            $display("FAIL basic_req got valid=%b addr=%h required 1 00001a40", mem_req_valid_o,
                     mem_req_addr_o);
        end
        checks++;
        if (w_bank_sel_o !== 2'd1 || w_bank_addr_o !== 8'h1A) begin
            errors++;
            $display("FAIL basic_split got bank=%0d set=%h required 1 1a", w_bank_sel_o, w_bank_addr_o);
        end
        checks++;
        if (miss_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got ready=%b busy=%b required 0 1", miss_ready_o, busy_o);
        end
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        cyc++;
        mem_req_ready_i = 1'b0;
        for (int b = 0; b < 8; b++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = line[b*64 +: 64];
            @(negedge clk_i);
            cyc++;
        end
        mem_rvalid_i = 1'b0;
        checks++;
        if (refill_done_o !== 1'b1 || we_way_mask_o !== 4'b0100) begin
            errors++;
            $display("FAIL basic_write at cycle %0d got done=%b we=%b required 1 0100", cyc,
                     refill_done_o, we_way_mask_o);
        end
        checks++;
        if (wdata_o[63:0] !== 64'h1111_1111_1111_1111 || wdata_o[511:448] !== 64'h8888_8888_8888_8888) begin
            errors++;
            $display("FAIL basic_wdata got lo=%h hi=%h required 1111111111111111 8888888888888888",
                     wdata_o[63:0], wdata_o[511:448]);
        end
        @(negedge clk_i);
        checks++;
        if (refill_done_o !== 1'b0 || miss_ready_o !== 1'b1 || we_way_mask_o !== 4'b0) begin
            errors++;
            $display("FAIL basic_after got done=%b ready=%b we=%b required 0 1 0000",
                     refill_done_o, miss_ready_o, we_way_mask_o);
        end
    endtask

    task automatic test_req_backpressure();
        logic [31:0]  a = 32'h0003_52C7;
        logic [511:0] line = rand_line();
        exp_q.push_back(exp_entry(a, 4'b0001, line));
        send_miss(a, 4'b0001);
        serve(a & 32'hFFFF_FFC0, line, 5, 1'b0, 1'b1);
    endtask

    task automatic test_beat_gaps();
        logic [31:0]  a = 32'hDEAD_BEEF;
        logic [511:0] line = rand_line();
        exp_q.push_back(exp_entry(a, 4'b1000, line));
        for (int i = 0; i < 3; i++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = junk();
            @(negedge clk_i);
        end
        send_miss(a, 4'b1000);
        serve(a & 32'hFFFF_FFC0, line, 2, 1'b1, 1'b1);
    endtask

    task automatic test_busy_rejection();
        logic [31:0]  a_a = 32'h0000_7F80;
        logic [31:0]  a_b = 32'h0001_2340;
        logic [511:0] l_a = rand_line();
        logic [511:0] l_b = rand_line();
        int           w0 = writes;
        exp_q.push_back(exp_entry(a_a, 4'b0010, l_a));
        exp_q.push_back(exp_entry(a_b, 4'b0001, l_b));
        send_miss(a_a, 4'b0010);
        miss_valid_i = 1'b1;
        miss_addr_i  = a_b;
        miss_way_i   = 4'b0001;
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        mem_req_ready_i = 1'b0;
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (miss_ready_o !== 1'b0 || w_bank_addr_o !== a_a[15:8] || w_bank_sel_o !== a_a[7:6]) begin
                errors++;
                $display("FAIL busy_hold beat %0d got ready=%b set=%h bank=%0d required 0 %h %0d",
                         b, miss_ready_o, w_bank_addr_o, w_bank_sel_o, a_a[15:8], a_a[7:6]);
            end
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = l_a[b*64 +: 64];
            @(negedge clk_i);
        end
        mem_rvalid_i = 1'b0;
        checks++;
        if (miss_ready_o !== 1'b0 || refill_done_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_write got ready=%b done=%b required 0 1", miss_ready_o, refill_done_o);
        end
        @(negedge clk_i);
        checks++;
        if (miss_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_release got ready=%b required 1", miss_ready_o);
        end
        @(negedge clk_i);
        miss_valid_i = 1'b0;
        serve(a_b & 32'hFFFF_FFC0, l_b, 0, 1'b0, 1'b0);
        checks++;
        if (writes - w0 !== 2) begin
            errors++;
            $display("FAIL busy_writes got %0d writes required 2", writes - w0);
        end
    endtask

    task automatic test_reset_mid_recv();
        logic [31:0]  a = 32'h0000_4440;
        logic [511:0] line = rand_line();
        int           w0 = writes;
        send_miss(a, 4'b0100);
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        mem_req_ready_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = junk();
            @(negedge clk_i);
        end
        mem_rvalid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (miss_ready_o !== 1'b1 || busy_o !== 1'b0 || mem_req_valid_o !== 1'b0 ||
            refill_done_o !== 1'b0 || we_way_mask_o !== 4'b0) begin
            errors++;
            $display("FAIL midreset_ctrl got ready=%b busy=%b req=%b done=%b we=%b required 1 0 0 0 0000",
                     miss_ready_o, busy_o, mem_req_valid_o, refill_done_o, we_way_mask_o);
        end
        checks++;
        if (wdata_o !== 512'b0 || w_bank_addr_o !== 8'h0 || mem_req_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL midreset_data got set=%h addr=%h wdata_lo=%h required zero", w_bank_addr_o,
                     mem_req_addr_o, wdata_o[63:0]);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (writes !== w0) begin
            errors++;
            $display("FAIL midreset_nowrite got %0d writes required %0d", writes, w0);
        end
        exp_q.push_back(exp_entry(a, 4'b0100, line));
        send_miss(a, 4'b0100);
        serve(a, line, 1, 1'b0, 1'b0);
    endtask

    task automatic test_zero_mask();
        logic [31:0]  a = 32'h00AB_CDC0;
        logic [511:0] line = rand_line();
        int           w0 = writes;
        exp_q.push_back(exp_entry(a, 4'b0000, line));
        send_miss(a, 4'b0000);
        serve(a, line, 0, 1'b0, 1'b0);
        checks++;
        if (writes - w0 !== 1) begin
            errors++;
            $display("FAIL zero_mask_done got %0d done pulses required 1", writes - w0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            logic [31:0]  a = $urandom;
            logic [3:0]   w = 4'b0001 << $urandom_range(0, 3);
            logic [511:0] line = rand_line();
            exp_q.push_back(exp_entry(a, w, line));
            send_miss(a, w);
            serve(a & 32'hFFFF_FFC0, line, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_refill();
        test_req_backpressure();
        test_beat_gaps();
        test_busy_rejection();
        test_reset_mid_recv();
        test_zero_mask();
        test_back_to_back();
        repeat (3) @(negedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending writes required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
